// File: rtl/tmr_redundancy_ctrl_if.sv
// Control/status bundle between the mode decoder, the redundancy controller and the replica/voter array.
interface tmr_redundancy_ctrl_if;
    logic [1:0] mode;
    logic [3:0] err_rate;
    logic [2:0] fault;
    logic [2:0] en;
    logic [2:0] rsync;
    logic       tmr_active;
    logic [2:0] state_o;
    logic [2:0] dead;

    modport master (
        output mode, err_rate, fault,
        input  en, rsync, tmr_active, state_o, dead
    );

    modport slave (
        input  mode, err_rate, fault,
        output en, rsync, tmr_active, state_o, dead
    );
endinterface

// File: rtl/tmr_redundancy_ctrl.sv
// Dynamic-TMR redundancy controller: replica enables, resync pulses, quarantine and retirement.
// Optional macro STRIKE_DECAY_EN: strikes decay after 256 fault-free TMR cycles per enabled replica.
module tmr_redundancy_ctrl #(
    parameter int unsigned ERR_HI      = 8,
    parameter int unsigned ERR_LO      = 4,
    parameter int unsigned WARMUP      = 4,
    parameter int unsigned HOLD        = 16,
    parameter int unsigned RETRY       = 32,
    parameter int unsigned FAULT_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    tmr_redundancy_ctrl_if.slave bus
);

    localparam int unsigned TMAX_WH = (WARMUP > HOLD) ? WARMUP : HOLD;
    localparam int unsigned TMAX    = (TMAX_WH > RETRY) ? TMAX_WH : RETRY;
    localparam int unsigned TW      = $clog2(TMAX) + 1;
    localparam int unsigned SW      = $clog2(FAULT_LIMIT + 1);

    localparam logic [3:0]    E_HI    = 4'(ERR_HI);
    localparam logic [3:0]    E_LO    = 4'(ERR_LO);
    localparam logic [TW-1:0] W_LAST  = TW'(WARMUP - 1);
    localparam logic [TW-1:0] D_HOLD  = TW'(HOLD);
    localparam logic [TW-1:0] T_RETRY = TW'(RETRY);
    localparam logic [SW-1:0] S_LIMIT = SW'(FAULT_LIMIT);

    typedef enum logic [2:0] {
        ST_SIMPLEX = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_TMR     = 3'd2,
        ST_SLEEP   = 3'd3
    } state_t;

    state_t             state_q, state_nx;
    logic [2:0]         en_q, en_nx;
    logic [2:0]         rsync_q, rsync_nx;
    logic [2:0]         dead_q, dead_nx;
    logic               tmr_q, tmr_nx;
    logic [2:0]         quar_q, quar_nx;
    logic [2:0][TW-1:0] qtmr_q, qtmr_nx;
    logic [2:0][SW-1:0] strike_q, strike_nx;
    logic [TW-1:0]      warm_q, warm_nx;
    logic [TW-1:0]      dwell_q, dwell_nx, dwell_inc;
    logic [2:0]         fault_v, qset, qexp, decay;
    logic               go_tmr, exit_ok;

    function automatic logic [1:0] pop3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    function automatic logic [2:0] primary(input logic [2:0] live);
        logic [2:0] r;
        r = 3'b000;
        if (live[0])      r = 3'b001;
        else if (live[1]) r = 3'b010;
        else if (live[2]) r = 3'b100;
        return r;
    endfunction

    // Voter flags are only meaningful with all three replicas voting; disabled replicas never strike.
    assign fault_v   = bus.fault & en_q & {3{tmr_q && (state_q == ST_TMR)}};
    assign dwell_inc = (dwell_q >= D_HOLD) ? D_HOLD : dwell_q + TW'(1);

`ifdef STRIKE_DECAY_EN
    logic [2:0][7:0] calm_q, calm_nx;

    always_comb begin
        calm_nx = calm_q;
        decay   = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (state_q == ST_TMR && en_q[k]) begin
                if (fault_v[k]) begin
                    calm_nx[k] = '0;
                end else begin
                    calm_nx[k] = calm_q[k] + 8'd1;
                    decay[k]   = (calm_q[k] == 8'hFF);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) calm_q <= '0;
        else     calm_q <= calm_nx;
    end
`else
    assign decay = '0;
`endif

    // Strike bookkeeping; a fault on a replica outranks its own retry expiry.
    always_comb begin
        dead_nx   = dead_q;
        strike_nx = strike_q;
        qset      = '0;
        qexp      = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (fault_v[k]) begin
                if (strike_q[k] != S_LIMIT) strike_nx[k] = strike_q[k] + SW'(1);
                if (strike_nx[k] == S_LIMIT) dead_nx[k] = 1'b1;
                else                         qset[k]    = 1'b1;
            end else begin
                if (decay[k] && !dead_q[k] && strike_q[k] != '0)
                    strike_nx[k] = strike_q[k] - SW'(1);
                qexp[k] = quar_q[k] && (qtmr_q[k] == TW'(1));
            end
        end
    end

    always_comb begin
        go_tmr  = (pop3(~dead_q) >= 2'd2) &&
                  ((bus.mode == 2'd2) ||
                   (bus.mode == 2'd0 && bus.err_rate >= E_HI) ||
                   (bus.mode == 2'd1 && (bus.err_rate >= E_HI || bus.err_rate != 4'd0)));
        exit_ok = (dwell_inc >= D_HOLD) &&
                  ((bus.mode == 2'd0 && bus.err_rate <= E_LO) ||
                   (bus.mode == 2'd1 && bus.err_rate == 4'd0));
        state_nx = state_q;
        if (bus.mode == 2'd3) begin
            state_nx = ST_SLEEP;
        end else begin
            case (state_q)
                ST_SIMPLEX: if (go_tmr) state_nx = ST_WARMUP;
                ST_WARMUP:  if (warm_q == W_LAST) state_nx = ST_TMR;
                ST_TMR:     if (pop3(~dead_nx) < 2'd2 || exit_ok) state_nx = ST_SIMPLEX;
                default:    state_nx = ST_SIMPLEX;
            endcase
        end
    end

    // Quarantine state only survives TMR->TMR; every other transition starts it clean.
    always_comb begin
        en_nx    = '0;
        rsync_nx = '0;
        quar_nx  = '0;
        qtmr_nx  = '0;
        warm_nx  = '0;
        dwell_nx = '0;
        case (state_nx)
            ST_SIMPLEX: en_nx = primary(~dead_nx);
            ST_WARMUP: begin
                en_nx = ~dead_nx & ~quar_nx;
                if (state_q == ST_WARMUP) warm_nx  = warm_q + TW'(1);
                else                      rsync_nx = en_nx & ~en_q;
            end
            ST_TMR: begin
                if (state_q == ST_TMR) begin
                    dwell_nx = dwell_inc;
                    for (int unsigned k = 0; k < 3; k++) begin
                        if (qset[k]) begin
                            quar_nx[k] = 1'b1;
                            qtmr_nx[k] = T_RETRY;
                        end else if (qexp[k]) begin
                            rsync_nx[k] = 1'b1;
                        end else if (quar_q[k]) begin
                            quar_nx[k] = 1'b1;
                            qtmr_nx[k] = qtmr_q[k] - TW'(1);
                        end
                    end
                end
                en_nx = ~dead_nx & ~quar_nx;
            end
            default: ;
        endcase
        tmr_nx = (state_nx == ST_TMR) && (en_nx == 3'b111);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SIMPLEX;
            en_q     <= 3'b001;
            rsync_q  <= '0;
            tmr_q    <= 1'b0;
            dead_q   <= '0;
            quar_q   <= '0;
            qtmr_q   <= '0;
            strike_q <= '0;
            warm_q   <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_nx;
            en_q     <= en_nx;
            rsync_q  <= rsync_nx;
            tmr_q    <= tmr_nx;
            dead_q   <= dead_nx;
            quar_q   <= quar_nx;
            qtmr_q   <= qtmr_nx;
            strike_q <= strike_nx;
            warm_q   <= warm_nx;
            dwell_q  <= dwell_nx;
        end
    end

    assign bus.en         = en_q;
    assign bus.rsync      = rsync_q;
    assign bus.tmr_active = tmr_q;
    assign bus.state_o    = state_q;
    assign bus.dead       = dead_q;

endmodule

// File: doc/tmr_redundancy_ctrl.md
Name: tmr_redundancy_ctrl

Overview:
Redundancy controller for the dynamic-TMR datapath. Decides per cycle which of the three processing replicas are enabled, based on operating mode, received error rate and the voter's fault vector. Sequences simplex/TMR transitions with warm-up and dwell timing, quarantines and resyncs faulty replicas, and retires replicas that fault repeatedly. Sits between the mode/err_rate decoder and the replica/voter array.

Parameters:
ERR_HI, 8, err_rate >= ERR_HI requests TMR (auto/hybrid)
ERR_LO, 4, err_rate <= ERR_LO permits return to simplex (auto/hybrid); ERR_LO < ERR_HI
WARMUP, 4, cycles replicas run in WARMUP before the voter is trusted
HOLD, 16, minimum TMR dwell in cycles before exit is allowed
RETRY, 32, quarantine length in cycles after a fault
FAULT_LIMIT, 3, strikes after which a replica is permanently dead

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
mode  in  2  0 auto, 1 hybrid, 2 manual, 3 sleep
err_rate  in  4  received-data error rate
fault  in  3  voter disagreement flags, one bit per replica, valid only while tmr_active=1
en  out  3  replica enables
rsync  out  3  one-cycle pulse: replica loads state from the voted output
tmr_active  out  1  voter output is trusted and fault is meaningful
state_o  out  3  FSM state probe
dead  out  3  permanently retired replicas

Behaviour:
- All outputs registered. Inputs sampled at a clock edge take effect on outputs at that same edge (1-cycle latency).
- Reset values: state SIMPLEX, en=001, rsync=000, tmr_active=0, dead=000, state_o=0; all strike counters, timers and quarantine flags cleared.
- live = ~dead. primary = lowest-index live replica.
- States and state_o encoding: SIMPLEX=0, WARMUP=1, TMR=2, SLEEP=3.
- SIMPLEX:
  - en = one-hot(primary); en=000 if all replicas are dead.
  - Go to WARMUP when any of the following holds, and at least 2 replicas are live:
    - mode=2;
    - mode=0 and err_rate>=ERR_HI;
    - mode=1 and (err_rate>=ERR_HI or err_rate!=0).
- WARMUP:
  - en = live & ~quarantined.
  - rsync pulses on the first WARMUP cycle for every newly enabled replica.
  - After WARMUP cycles go to TMR; the dwell counter starts at 0.
- TMR:
  - tmr_active=1 only while popcount(en)==3; with 2 enabled the block stays in TMR as a degraded duplex and tmr_active=0.
  - fault is processed only while tmr_active=1.
  - For each asserted bit k, processed in the same cycle, independently:
    - strike[k] increments, saturating at FAULT_LIMIT;
    - if strike[k]==FAULT_LIMIT then dead[k]=1 and en[k]=0 permanently;
    - otherwise replica k is quarantined: en[k]=0 and its RETRY timer loads.
  - When the RETRY timer expires: en[k]=1 and rsync[k]=1 for exactly one cycle.
  - Fault bits on already-disabled replicas are ignored.
  - Exit to SIMPLEX when dwell>=HOLD and either:
    - mode=0 with err_rate<=ERR_LO;
    - mode=1 with err_rate==0.
  - Manual mode never exits on its own.
  - Drop to SIMPLEX immediately, ignoring HOLD, if fewer than 2 replicas are live.
  - Entering SIMPLEX clears quarantine flags and timers; strikes are kept.
- SLEEP:
  - Entered from any state on the cycle after mode=3 is sampled, including mid-WARMUP and mid-quarantine.
  - en=000, rsync=000, tmr_active=0; timers and quarantines cleared, strikes and dead kept.
  - When mode!=3, go to SIMPLEX; normal entry conditions are evaluated from there.
- Simultaneous events:
  - SLEEP request has priority over any other transition.
  - A fault pulse in the same cycle as a TMR exit is still counted.
  - A RETRY expiry in the same cycle as a new fault on the same replica: the fault wins (timer reloads, no rsync).
- Counters: dwell saturates at HOLD. Timer widths are $clog2(max(WARMUP,HOLD,RETRY))+1.

Optional Feature:
- STRIKE_DECAY_EN defined:
  - Each replica has a 256-cycle fault-free counter, running only in TMR while the replica is enabled.
  - On wrap, strike[k] decrements by 1, floored at 0; dead replicas never decay.
- STRIKE_DECAY_EN undefined: strikes are cleared only by reset.

Test Plan:
- Reset, then release with mode=0, err_rate=0 -> en=001, state_o=0, tmr_active=0, dead=000, held for 20 cycles.
- mode=0, err_rate=10 -> next cycle state_o=1, en=111, rsync=110 for 1 cycle; after 4 cycles state_o=2, tmr_active=1.
- From TMR entry, drop err_rate to 2 at once -> stays TMR for 16 cycles, then state_o=0, en=001, tmr_active=0; err_rate=6 at any time -> no exit.
- mode=2, single-cycle fault=010 in TMR -> en=101 and tmr_active=0 for 32 cycles, then en=111, rsync=010 for 1 cycle; third such pulse -> dead=010, en=101 permanently.
- Retire replica 0 via 3 faults, then mode=0, err_rate=0 after HOLD -> SIMPLEX with en=010 (new primary).
- mode=3 asserted on the 2nd WARMUP cycle -> next cycle state_o=3, en=000; then mode=0, err_rate=0 -> state_o=0, en=001, strikes unchanged.
